audio_dac_sequencer: RTL
========================

AUDIO_DAC_SEQUENCER -- requirements
Module: audio_dac_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, meaning bits per channel sample (legal 8..24).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning stereo-frame FIFO entries (power of 2, 2..16).
REQ-003 clk_clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = sequencer running; 0 = DACDAT held 0, FIFO flushed, state forced to IDLE.
REQ-006 smp_data  input  2*DATA_W  stereo frame; left in upper half, right in lower half.
REQ-007 smp_valid  input  1  smp_data valid.
REQ-008 smp_ready  output  1  FIFO can accept a frame.
REQ-009 audio_0_external_interface_BCLK  input  1  codec bit clock, asynchronous to clk_clk.
REQ-010 audio_0_external_interface_DACLRCK  input  1  codec word clock (0 = left, 1 = right), asynchronous.
REQ-011 audio_0_external_interface_DACDAT  output  1  serial DAC data, I2S format.
REQ-012 underflow  output  1  one-cycle pulse when a frame is due and the FIFO is empty.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 BCLK and DACLRCK shall each pass a 2-flop synchronizer followed by an edge-detect flop; events are the synchronized rising/falling edges.
REQ-015 Frame push shall occur on a cycle with smp_valid and smp_ready both 1; smp_ready = (fifo_level < FIFO_DEPTH) and enable.
REQ-016 Simultaneous push and pop in one cycle shall leave fifo_level unchanged; pop on empty and push on full shall not occur.
REQ-017 States: IDLE, DELAY, SHIFT, PAD.
REQ-018 IDLE -> DELAY on the first DACLRCK falling edge with enable=1; edges arriving mid-word after reset/enable shall be ignored until then.
REQ-019 On a DACLRCK falling edge: pop one frame into a 2*DATA_W holding register, load the left half into the shift register, enter DELAY.
REQ-020 On a DACLRCK rising edge: load the right half from the holding register (no pop), enter DELAY.
REQ-021 DELAY -> SHIFT on the next BCLK falling edge; DACDAT stays 0 during DELAY (I2S one-bit delay).
REQ-022 SHIFT: on each BCLK falling edge, DACDAT shall present the next bit MSB first; after DATA_W bits, go to PAD.
REQ-023 PAD: DACDAT = 0 until the next DACLRCK edge.
REQ-024 A DACLRCK edge in DELAY or SHIFT shall abort the current word and start the new word per REQ-019/020.
REQ-025 DACDAT shall be registered; it changes 1 clk_clk cycle after the synchronized BCLK falling edge is detected.
REQ-026 On a DACLRCK falling edge with FIFO empty: underflow pulses for 1 cycle and the substituted frame follows REQ-033/034.
REQ-027 enable deasserted shall take effect in the next cycle: fifo_level to 0, state IDLE, DACDAT 0.

Reset
REQ-028 On reset_reset=1 the block shall clear immediately, without waiting for a clock edge.
REQ-029 Reset values: DACDAT=0, smp_ready=0, underflow=0, fifo_level=0, state IDLE, holding register 0, synchronizer flops 0.
REQ-030 Reset asserted mid-word shall truncate the word; after release the block re-aligns per REQ-018.
REQ-031 smp_ready shall rise in the first cycle after reset release when enable=1.

Configuration
REQ-032 Macro AUDIO_DAC_REPEAT_ON_UNDERFLOW_EN selects the underflow substitution.
REQ-033 With AUDIO_DAC_REPEAT_ON_UNDERFLOW_EN defined, the holding register shall keep the last frame and replay it.
REQ-034 With AUDIO_DAC_REPEAT_ON_UNDERFLOW_EN undefined, the holding register shall load all-zeros (silence).

Verification
REQ-035 Scenario: DATA_W=16; push 0xA5A5_3C3C; BCLK=64 clk periods; LRCK=32 BCLK -> DACDAT shows 0, then A5A5 MSB-first, 15 zeros, 0, then 3C3C MSB-first, 15 zeros.
REQ-036 Scenario: push 5 frames with FIFO_DEPTH=4 and no LRCK edges -> smp_ready=0 after 4 pushes, fifo_level=4, 5th frame accepted only after the next LRCK falling edge.
REQ-037 Scenario: FIFO empty at LRCK falling edge -> underflow pulses for exactly 1 cycle; macro undefined gives 32 zero bits; macro defined replays previous frame.
REQ-038 Scenario: reset_reset asserted in mid-SHIFT, bit 7 -> DACDAT=0 with no clock edge; after release, output stays 0 until the first LRCK falling edge.
REQ-039 Scenario: enable dropped with fifo_level=3 -> next cycle fifo_level=0, DACDAT=0, smp_ready=0.
REQ-040 Scenario: push and pop on the same cycle at fifo_level=2 -> fifo_level stays 2, with no data loss or reordering over 8 frames.

Source files
------------

// File: rtl/audio_dac_sequencer.sv
// I2S DAC sequencer: a stereo-frame FIFO feeding a serializer locked to the codec BCLK/DACLRCK.
// Define AUDIO_DAC_REPEAT_ON_UNDERFLOW_EN to replay the last frame on underflow instead of silence.
module audio_dac_sequencer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        enable,
    input  logic [2*DATA_W-1:0]         smp_data,
    input  logic                        smp_valid,
    output logic                        smp_ready,
    input  logic                        audio_0_external_interface_BCLK,
    input  logic                        audio_0_external_interface_DACLRCK,
    output logic                        audio_0_external_interface_DACDAT,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DATA_W_L = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        PAD
    } state_t;

    logic [1:0]            bclk_sync_q, bclk_sync_d;
    logic                  bclk_prev_q, bclk_prev_d;
    logic [1:0]            lrck_sync_q, lrck_sync_d;
    logic                  lrck_prev_q, lrck_prev_d;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2*DATA_W-1:0]   hold_q, hold_d;
    logic                  dacdat_q, dacdat_d;
    logic                  underflow_q, underflow_d;
    logic                  smp_ready_q, smp_ready_d;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [2*DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic                  bclk_fall;
    logic                  lrck_fall;
    logic                  lrck_rise;
    logic                  push;
    logic                  pop;
    logic [2*DATA_W-1:0]   head;

    always_comb begin
        bclk_sync_d = {bclk_sync_q[0], audio_0_external_interface_BCLK};
        bclk_prev_d = bclk_sync_q[1];
        lrck_sync_d = {lrck_sync_q[0], audio_0_external_interface_DACLRCK};
        lrck_prev_d = lrck_sync_q[1];

        bclk_fall = bclk_prev_q & ~bclk_sync_q[1];
        lrck_fall = lrck_prev_q & ~lrck_sync_q[1];
        lrck_rise = ~lrck_prev_q & lrck_sync_q[1];

        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        dacdat_d    = dacdat_q;
        underflow_d = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        head        = fifo_mem_q[rd_ptr_q];
        push        = smp_valid && smp_ready_q && enable;
        pop         = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            dacdat_d  = 1'b0;
            bit_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end else begin
            // Word-clock edges take priority over BCLK and restart the word from any state.
            if (lrck_fall) begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    shreg_d = head[2*DATA_W-1:DATA_W];
                end else begin
                    underflow_d = 1'b1;
`ifdef AUDIO_DAC_REPEAT_ON_UNDERFLOW_EN
                    hold_d  = hold_q;
                    shreg_d = hold_q[2*DATA_W-1:DATA_W];
`else
                    hold_d  = '0;
                    shreg_d = '0;
`endif
                end
                state_d   = DELAY;
                dacdat_d  = 1'b0;
                bit_cnt_d = '0;
            end else if (lrck_rise && (state_q != IDLE)) begin
                shreg_d   = hold_q[DATA_W-1:0];
                state_d   = DELAY;
                dacdat_d  = 1'b0;
                bit_cnt_d = '0;
            end else if (bclk_fall) begin
                case (state_q)
                    DELAY: begin
                        state_d   = SHIFT;
                        dacdat_d  = shreg_q[DATA_W-1];
                        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = CNT_W'(1);
                    end
                    SHIFT: begin
                        if (bit_cnt_q == DATA_W_L) begin
                            state_d  = PAD;
                            dacdat_d = 1'b0;
                        end else begin
                            dacdat_d  = shreg_q[DATA_W-1];
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    default: dacdat_d = 1'b0;
                endcase
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        // Registered ready reflects the occupancy the FIFO will have after this edge.
        smp_ready_d = enable && (level_d < DEPTH_L);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bclk_sync_q <= '0;
            bclk_prev_q <= 1'b0;
            lrck_sync_q <= '0;
            lrck_prev_q <= 1'b0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
            smp_ready_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            bclk_prev_q <= bclk_prev_d;
            lrck_sync_q <= lrck_sync_d;
            lrck_prev_q <= lrck_prev_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            dacdat_q    <= dacdat_d;
            underflow_q <= underflow_d;
            smp_ready_q <= smp_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= smp_data;
        end
    end

    assign smp_ready                         = smp_ready_q;
    assign audio_0_external_interface_DACDAT = dacdat_q;
    assign underflow                         = underflow_q;
    assign fifo_level                        = level_q;

endmodule
